forward_stall_unit: RTL and testbench
=====================================

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of source operands checked per decode slot.
REQ-002 SHALL have parameter FWD_DEPTH, default 2, number of downstream stages tracked (stage 1 = EXE, 2 = LS, ...); legal range 1..7.
REQ-003 SHALL have parameter REG_AW, default 5, register-address width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs  in  NUM_SRC*REG_AW  decode source addresses; slice i = source i
- rs_used  in  NUM_SRC  source i is actually read
- id_rd  in  REG_AW  decode destination
- id_rd_wr  in  1  decode instruction writes id_rd
- id_is_load  in  1  decode instruction is a load
- id_valid  in  1  decode slot holds a real instruction
- flush  in  1  squash decode instruction
- hold  in  1  whole pipeline frozen
- fwd_sel  out  NUM_SRC*SEL_W  per-source forward select, SEL_W = clog2(FWD_DEPTH+1)
- stall  out  1  load-use stall request to fetch/decode
- stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-006 SHALL hold a tracker of FWD_DEPTH entries, each {rd, wr, ld}; entry k mirrors the instruction in stage k.
REQ-007 When hold=0, entry k SHALL load entry k-1 for k>=2 on every rising edge.
REQ-008 When hold=0, entry 1 SHALL load {id_rd, id_rd_wr & id_valid, id_is_load} unless stall=1 or flush=1, in which case it SHALL load a bubble {0,0,0}.
REQ-009 When hold=1, all entries and stall_cnt SHALL keep their values; outputs remain combinational on current state.
REQ-010 fwd_sel[i] SHALL be 0 (NONE) if rs[i]==0 or rs_used[i]==0.
REQ-011 Otherwise fwd_sel[i] SHALL be the smallest k with entry k wr=1 and rd==rs[i]; 0 if no match (youngest producer wins).
REQ-012 An entry with wr=1 and rd==0 SHALL never match.
REQ-013 stall SHALL be 1 when, for any i with rs_used[i]=1 and rs[i]!=0, entry 1 has wr=1, ld=1 and rd==rs[i], and id_valid=1; else 0.
REQ-014 stall SHALL be combinational, zero-latency; fwd_sel values are don't-care to consumers while stall=1 but SHALL still follow REQ-010/011.
REQ-015 A load in entry k>=2 SHALL forward normally (fwd_sel=k), no stall.
REQ-016 flush SHALL take priority over stall for entry 1 capture; stall output is still computed.
REQ-017 stall_cnt SHALL increment by 1 on each edge with stall=1 and hold=0, and SHALL saturate at 2^CNT_W-1.
REQ-018 After a single-cycle load-use stall, the reissued instruction SHALL see the load in entry 2 and get fwd_sel=2 with stall=0.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all entries to {0,0,0} and stall_cnt to 0.
REQ-020 During and after reset, fwd_sel SHALL be all 0 and stall 0 until a writing instruction is captured.
REQ-021 Reset asserted mid-stall SHALL drop stall in the same cycle; no state is retained.

Structure
REQ-022 Shared control package SHALL hold FWD_NONE=0 and the tracker-entry struct type; SEL_W SHALL derive from FWD_DEPTH locally.
REQ-023 Per-source match/priority logic SHALL be one sub-module, fwd_src_match, instantiated NUM_SRC times via generate.
REQ-024 The existing two-stage forwarding encoding SHALL map as FROM_EXE=1, FROM_LS=2 at FWD_DEPTH=2.

Verification
REQ-025 Writer x5 (ALU) issued, next instr reads rs1=x5 -> fwd_sel[0]=1, stall=0; one cycle later unrelated instr reads x5 -> fwd_sel=2.
REQ-026 Load to x7, next instr rs2=x7 -> stall=1 one cycle, stall_cnt=1; reissue -> fwd_sel[1]=2, stall=0.
REQ-027 Two back-to-back writers of x3, then reader of x3 -> fwd_sel=1 (youngest); writer of x0 then reader of x0 -> fwd_sel=0.
REQ-028 Load x9 with flush=1 in same cycle -> entry 1 bubble; next reader of x9 -> fwd_sel=0, stall=0.
REQ-029 hold=1 for 3 cycles with load-use pending -> entries frozen, stall stays 1, stall_cnt unchanged; hold=0 -> count increments.
REQ-030 FWD_DEPTH=4, NUM_SRC=3, CNT_W=2: writer x1 then 3 bubbles -> fwd_sel 1,2,3,4,0 over successive cycles; 5 stall cycles -> stall_cnt=3; rst_n low mid-stall -> stall=0, stall_cnt=0 immediately.

Source files
------------

// File: rtl/forward_stall_unit_pkg.sv
// Shared definitions for the operand-forwarding / load-use stall unit.
// Tracker entries carry a fixed-width rd so the struct can live here; REG_AW must not exceed RD_W_MAX.
package forward_stall_unit_pkg;

    localparam int FWD_NONE = 0;
    localparam int FROM_EXE = 1;
    localparam int RD_W_MAX = 16;

    typedef struct packed {
        logic [RD_W_MAX-1:0] rd;
        logic                wr;
        logic                ld;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '0;

endpackage

// File: rtl/fwd_src_match.sv
// Per-source producer search: youngest matching writer wins, and a load
// sitting in the first downstream stage is reported as a load-use hazard.
module fwd_src_match
    import forward_stall_unit_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = 5,
    parameter int SEL_W     = 2
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  trk_entry_t        trk [FWD_DEPTH],
    output logic [SEL_W-1:0]  sel,
    output logic              load_use
);

    logic                 rs_live;
    logic [FWD_DEPTH-1:0] hit;
    logic [FWD_DEPTH-1:0] is_ld;
    logic [FWD_DEPTH-1:0] first_stage;

    assign rs_live     = rs_used && (rs != '0);
    assign first_stage = FWD_DEPTH'(1);

    // A writer of x0 can never hit because rs_live already excludes rs == 0.
    always_comb begin
        hit   = '0;
        is_ld = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            hit[k]   = rs_live && trk[k].wr && (trk[k].rd == RD_W_MAX'(rs));
            is_ld[k] = trk[k].ld;
        end
    end

    always_comb begin
        sel = SEL_W'(FWD_NONE);
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(FROM_EXE + k);
            end
        end
    end

    // Only a load one stage ahead stalls; deeper loads already have their data.
    assign load_use = |(hit & is_ld & first_stage);

endmodule

// File: rtl/forward_stall_unit.sv
// Tracks destination registers of downstream stages, selects forwarding
// sources per decode operand and raises a load-use stall with a saturating count.
module forward_stall_unit
    import forward_stall_unit_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int FWD_DEPTH = 2,
    parameter  int REG_AW    = 5,
    parameter  int CNT_W     = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]  rs,
    input  logic [NUM_SRC-1:0]         rs_used,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_rd_wr,
    input  logic                       id_is_load,
    input  logic                       id_valid,
    input  logic                       flush,
    input  logic                       hold,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_cnt
);

    trk_entry_t         trk [FWD_DEPTH];
    trk_entry_t         id_entry;
    logic [NUM_SRC-1:0] load_use;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .REG_AW    (REG_AW),
            .SEL_W     (SEL_W)
        ) u_match (
            .rs       (rs[i*REG_AW +: REG_AW]),
            .rs_used  (rs_used[i]),
            .trk      (trk),
            .sel      (fwd_sel[i*SEL_W +: SEL_W]),
            .load_use (load_use[i])
        );
    end

    assign stall = id_valid & (|load_use);

    // A stalled or squashed decode slot enters the pipe as a bubble; flush wins.
    always_comb begin
        id_entry    = TRK_BUBBLE;
        id_entry.rd = RD_W_MAX'(id_rd);
        id_entry.wr = id_rd_wr & id_valid;
        id_entry.ld = id_is_load;
        if (stall || flush) begin
            id_entry = TRK_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                trk[k] <= TRK_BUBBLE;
            end
            stall_cnt <= '0;
        end else if (!hold) begin
            trk[0] <= id_entry;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                trk[k] <= trk[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_stall_unit.sv
// Directed bench: default configuration plus a deep/narrow-counter instance.
module tb_forward_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: NUM_SRC=2, FWD_DEPTH=2, REG_AW=5, CNT_W=16
    logic        rst_n;
    logic [9:0]  rs;
    logic [1:0]  rs_used;
    logic [4:0]  id_rd;
    logic        id_rd_wr, id_is_load, id_valid, flush, hold;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    // Deep instance: NUM_SRC=3, FWD_DEPTH=4, REG_AW=5, CNT_W=2
    logic        rst4_n;
    logic [14:0] rs4;
    logic [2:0]  rs_used4;
    logic [4:0]  id_rd4;
    logic        id_rd_wr4, id_is_load4, id_valid4, flush4, hold4;
    logic [8:0]  fwd_sel4;
    logic        stall4;
    logic [1:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    forward_stall_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs         (rs),
        .rs_used    (rs_used),
        .id_rd      (id_rd),
        .id_rd_wr   (id_rd_wr),
        .id_is_load (id_is_load),
        .id_valid   (id_valid),
        .flush      (flush),
        .hold       (hold),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    forward_stall_unit #(
        .NUM_SRC   (3),
        .FWD_DEPTH (4),
        .REG_AW    (5),
        .CNT_W     (2)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst4_n),
        .rs         (rs4),
        .rs_used    (rs_used4),
        .id_rd      (id_rd4),
        .id_rd_wr   (id_rd_wr4),
        .id_is_load (id_is_load4),
        .id_valid   (id_valid4),
        .flush      (flush4),
        .hold       (hold4),
        .fwd_sel    (fwd_sel4),
        .stall      (stall4),
        .stall_cnt  (stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                       input logic [4:0] rd, input logic wr, input logic ld,
                       input logic valid, input logic fl, input logic hd);
        rs         = {r1, r0};
        rs_used    = used;
        id_rd      = rd;
        id_rd_wr   = wr;
        id_is_load = ld;
        id_valid   = valid;
        flush      = fl;
        hold       = hd;
        #1;
    endtask

    task automatic drv4(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] used, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic valid);
        rs4         = {r2, r1, r0};
        rs_used4    = used;
        id_rd4      = rd;
        id_rd_wr4   = wr;
        id_is_load4 = ld;
        id_valid4   = valid;
        flush4      = 1'b0;
        hold4       = 1'b0;
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        drv(5'd7, 5'd7, 2'b11, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drv4(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        // Reset: nothing captured even with a load offered at decode
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        tick();

        // ALU writer x5, then readers one and two cycles later
        drv(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drv(5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("alu_fwd_exe", 32'(fwd_sel[1:0]), 32'd1);
        chk("alu_no_stall", 32'(stall), 32'd0);
        tick();
        drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("alu_fwd_ls", 32'(fwd_sel[1:0]), 32'd2);
        drv(5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("unused_src", 32'(fwd_sel[1:0]), 32'd0);
        tick();

        // Load x7 followed by a reader on source 1
        drv(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_sel_during", 32'(fwd_sel[3:2]), 32'd1);
        chk("lu_cnt_before", 32'(stall_cnt), 32'd0);
        drv(5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_invalid_no_stall", 32'(stall), 32'd0);
        drv(5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lu_cnt_after", 32'(stall_cnt), 32'd1);
        chk("lu_reissue_stall", 32'(stall), 32'd0);
        chk("lu_reissue_sel", 32'(fwd_sel[3:2]), 32'd2);
        tick();

        // Back-to-back writers of x3: youngest wins
        drv(5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drv(5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("youngest_wins", 32'(fwd_sel[1:0]), 32'd1);
        tick();
        // Writer of x0 is never a forwarding source
        drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drv(5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("x0_no_fwd", 32'(fwd_sel), 32'd0);
        tick();

        // Flushed load of x9 leaves a bubble
        drv(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drv(5'd9, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_no_fwd", 32'(fwd_sel), 32'd0);
        chk("flush_no_stall", 32'(stall), 32'd0);
        tick();

        // Hold with a load-use pending freezes the tracker and the counter
        drv(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("hold_stall", 32'(stall), 32'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("hold_stall_kept", 32'(stall), 32'd1);
            chk("hold_cnt_frozen", 32'(stall_cnt), 32'd1);
            chk("hold_sel_frozen", 32'(fwd_sel[1:0]), 32'd1);
        end
        drv(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("unhold_stall", 32'(stall), 32'd1);
        tick();
        chk("unhold_cnt", 32'(stall_cnt), 32'd2);
        chk("unhold_no_stall", 32'(stall), 32'd0);
        chk("unhold_sel", 32'(fwd_sel[1:0]), 32'd2);

        // Deep instance: writer x1 walks down four stages then leaves
        drv4(5'd0, 5'd0, 5'd0, 3'b000, 5'd1, 1'b1, 1'b0, 1'b1);
        tick();
        drv4(5'd0, 5'd0, 5'd1, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        while (exp_q.size() > 0) begin
            chk("deep_walk", 32'(fwd_sel4[8:6]), exp_q.pop_front());
            tick();
        end

        // Five separate load-use stalls saturate the 2-bit counter
        for (int n = 1; n <= 5; n++) begin
            drv4(5'd0, 5'd0, 5'd0, 3'b000, 5'd2, 1'b1, 1'b1, 1'b1);
            tick();
            drv4(5'd2, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1);
            chk("deep_stall", 32'(stall4), 32'd1);
            tick();
            chk("deep_cnt", 32'(stall_cnt4), (n < 3) ? 32'(n) : 32'd3);
        end

        // Reset mid-stall drops everything immediately
        drv4(5'd0, 5'd0, 5'd0, 3'b000, 5'd2, 1'b1, 1'b1, 1'b1);
        tick();
        drv4(5'd2, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_stall", 32'(stall4), 32'd1);
        rst4_n = 1'b0;
        #1;
        chk("mid_reset_stall", 32'(stall4), 32'd0);
        chk("mid_reset_cnt", 32'(stall_cnt4), 32'd0);
        chk("mid_reset_sel", 32'(fwd_sel4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
